// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Signed operation is compiled in only when MULDIV_SIGNED_EN is defined; otherwise sign is ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             r_state;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_opnd;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_SIGNED_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_neg_q;
    logic w_neg_r;

    function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

    assign w_a_mag = sign ? f_abs(a) : a;
    assign w_b_mag = sign ? f_abs(b) : b;
    assign w_neg_q = sign & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign w_neg_r = sign & a[WIDTH-1];
`else
    logic w_unused_sign;
    assign w_unused_sign = sign;
    assign w_a_mag = a;
    assign w_b_mag = b;
`endif

    // Multiply: upper half accumulates, multiplier bits shift out of the lower half.
    assign w_sum     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_p[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, quotient bits shift into the lower half.
    assign w_trial   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]} - {1'b0, r_opnd};
    assign w_div_nxt = {(w_trial[WIDTH] ? {r_p[2*WIDTH-2:WIDTH], r_p[WIDTH-1]} : w_trial[WIDTH-1:0]),
                        r_p[WIDTH-2:0], ~w_trial[WIDTH]};

    always_comb begin
        w_res_hi = (r_state == MULT) ? w_mul_nxt[2*WIDTH-1:WIDTH] : w_div_nxt[2*WIDTH-1:WIDTH];
        w_res_lo = (r_state == MULT) ? w_mul_nxt[WIDTH-1:0]       : w_div_nxt[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (r_state == MULT) begin
            if (r_neg_q) {w_res_hi, w_res_lo} = -w_mul_nxt;
        end else begin
            if (r_neg_q) w_res_lo = -w_div_nxt[WIDTH-1:0];
            if (r_neg_r) w_res_hi = -w_div_nxt[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_p      <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (start) begin
                        r_cnt <= '0;
`ifdef MULDIV_SIGNED_EN
                        r_neg_q <= w_neg_q;
                        r_neg_r <= w_neg_r;
`endif
                        if (!op) begin
                            r_state <= MULT;
                            busy    <= 1'b1;
                            r_p     <= {{WIDTH{1'b0}}, w_b_mag};
                            r_opnd  <= w_a_mag;
                        end else if (b != '0) begin
                            r_state <= DIV;
                            busy    <= 1'b1;
                            r_p     <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opnd  <= w_b_mag;
                        end else begin
                            // Zero divisor: report immediately, keep previous hi/lo.
                            r_state  <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end
                    end
                end
                MULT, DIV: begin
                    r_p   <= (r_state == MULT) ? w_mul_nxt : w_div_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state  <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        hi       <= w_res_hi;
                        lo       <= w_res_lo;
                        div_zero <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32; expectations follow MULDIV_SIGNED_EN.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        sign = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sign(sign),
        .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, let edge 0 sample it; returns during cycle 1.
    task automatic go(input logic op_i, input logic sign_i, input logic [31:0] a_i, input logic [31:0] b_i);
        start = 1'b1; op = op_i; sign = sign_i; a = a_i; b = b_i;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int bad;
        int pulses;

        // Reset state
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_zero, 0);
        rst = 1'b1;
        tick();

        // Unsigned max * max, busy through cycles 1..32
        go(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bad = 0;
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        check("mul_busy_window", bad, 0);
        check("mul_done33", done, 1);
        check("mul_busy33", busy, 0);
        check("mul_hi", hi, 32'hFFFF_FFFE);
        check("mul_lo", lo, 32'h0000_0001);
        tick();
        check("mul_done_pulse", done, 0);

        // Unsigned 100/7, then divide by zero
        go(1'b1, 1'b0, 32'd100, 32'd7);
        repeat (32) tick();
        check("div_done33", done, 1);
        check("div_lo", lo, 14);
        check("div_hi", hi, 2);
        check("div_dz", div_zero, 0);
        tick();
        go(1'b1, 1'b0, 32'd5, 32'd0);
        check("dz_done1", done, 1);
        check("dz_busy", busy, 0);
        check("dz_flag", div_zero, 1);
        check("dz_hi_kept", hi, 2);
        check("dz_lo_kept", lo, 14);
        tick();
        check("dz_done_pulse", done, 0);

        // -7 / 2 with sign requested
        go(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
        repeat (32) tick();
        check("sdiv_done", done, 1);
        check("sdiv_dz_clear", div_zero, 0);
`ifdef MULDIV_SIGNED_EN
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);
`else
        check("sdiv_lo", lo, 32'h7FFF_FFFC);
        check("sdiv_hi", hi, 32'h0000_0001);
`endif
        tick();

        // -3 * 4 with sign requested
        go(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4);
        repeat (32) tick();
`ifdef MULDIV_SIGNED_EN
        check("smul_hi", hi, 32'hFFFF_FFFF);
        check("smul_lo", lo, 32'hFFFF_FFF4);
`else
        check("smul_hi", hi, 32'h0000_0003);
        check("smul_lo", lo, 32'hFFFF_FFF4);
`endif
        tick();

`ifdef MULDIV_SIGNED_EN
        // Most-negative / -1 wraps without a flag
        go(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (32) tick();
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0000_0000);
        check("ovf_dz", div_zero, 0);
        tick();
`endif

        // Reset in the middle of 6*7, start held during reset
        go(1'b0, 1'b0, 32'd6, 32'd7);
        repeat (9) tick();
        rst = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
        tick();
        check("abort_start_ignored", busy, 0);
        start = 1'b0;
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 0);

        // start while busy ignored; back-to-back start in DONE
        go(1'b0, 1'b0, 32'd5, 32'd9);
        for (int c = 1; c <= 32; c++) begin
            start = (c == 5 || c == 20);
            op = 1'b1; a = 32'd1; b = 32'd1;
            tick();
        end
        start = 1'b0;
        check("ign_done33", done, 1);
        check("ign_lo", lo, 45);
        check("ign_hi", hi, 0);
        go(1'b0, 1'b0, 32'd3, 32'd3);
        check("b2b_done_pulse", done, 0);
        check("b2b_busy", busy, 1);
        repeat (32) tick();
        check("b2b_done66", done, 1);
        check("b2b_lo", lo, 9);
        check("b2b_hi", hi, 0);
        tick();
        check("b2b_done_end", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: operand/result width in bits, legal 4..64.
REQ-002 The module SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-003 The module SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1: request, sampled only in IDLE or DONE.
REQ-005 The module SHALL have port op, input, 1: operation select, 0 = multiply, 1 = divide; sampled with start.
REQ-006 The module SHALL have port sign, input, 1: operation mode, 1 = signed, 0 = unsigned; sampled with start.
REQ-007 The module SHALL have ports a and b, input, WIDTH: operands (multiplicand/multiplier; dividend/divisor), sampled with start.
REQ-008 The module SHALL have port busy, output, 1: high while in MULT or DIV.
REQ-009 The module SHALL have port done, output, 1: one-cycle pulse, high only in DONE.
REQ-010 The module SHALL have ports hi and lo, output, WIDTH: result registers.
REQ-011 The module SHALL have port div_zero, output, 1: last accepted divide had b == 0.

Function
REQ-012 The FSM SHALL have states IDLE, MULT, DIV, DONE.
REQ-013 Transitions SHALL be: IDLE/DONE + start & !op -> MULT; IDLE/DONE + start & op & b!=0 -> DIV; IDLE/DONE + start & op & b==0 -> DONE; MULT/DIV -> DONE after exactly WIDTH iteration cycles; DONE without start -> IDLE.
REQ-014 Multiply SHALL be iterative shift-add, one multiplier bit per cycle; {hi,lo} = full 2*WIDTH-bit product.
REQ-015 Divide SHALL be iterative restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
REQ-016 Latency SHALL be: start sampled at edge 0 -> done high during cycle WIDTH+1; zero-divisor case -> done high during cycle 1.
REQ-017 hi/lo SHALL update only on entry to DONE and hold until the next result; iteration state SHALL be internal registers.
REQ-018 start while busy SHALL be ignored, with no effect on state or operands.
REQ-019 start in DONE SHALL be accepted (back-to-back); done still pulses exactly one cycle.
REQ-020 Divide by zero SHALL set div_zero=1 and leave hi/lo unchanged; any other accepted op SHALL clear div_zero on entry to DONE.
REQ-021 Signed ops SHALL operate on magnitudes, then apply signs: product sign = a^b; quotient truncates toward zero; remainder takes dividend sign.
REQ-022 Signed most-negative / -1 SHALL give lo = most-negative value (wrap) and hi = 0, with no flag.

Reset
REQ-023 rst low at a clock edge SHALL force IDLE and busy=0, done=0, hi=0, lo=0, div_zero=0, clearing all iteration registers.
REQ-024 Reset mid-operation SHALL abort without a done pulse; start during reset SHALL be ignored.

Configuration
REQ-025 With macro MULDIV_SIGNED_EN defined, sign SHALL be honoured per REQ-021/022.
REQ-026 Without MULDIV_SIGNED_EN, the sign port SHALL remain present but be ignored, all ops SHALL be unsigned, and no sign-correction logic SHALL be synthesised.

Verification (WIDTH=32)
REQ-027 Multiply, unsigned, a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done in cycle 33, busy cycles 1..32.
REQ-028 Divide, unsigned, 100/7 -> lo=14, hi=2, div_zero=0; then 5/0 -> done in cycle 1, div_zero=1, hi=2, lo=14 retained.
REQ-029 Divide, sign=1, a=0xFFFFFFF9 (-7), b=2 -> with macro: lo=0xFFFFFFFD, hi=0xFFFFFFFF; without macro: lo=0x7FFFFFFC, hi=1.
REQ-030 Divide with macro, signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; multiply signed -3*4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4.
REQ-031 Multiply 6*7 started, rst low at cycle 10 -> cycle 11 shows busy=0, hi=lo=0, and no done pulse follows.
REQ-032 start pulsed in cycles 5 and 20 of a multiply -> both ignored; start in DONE cycle 33 with 3*3 -> done in cycle 66 with lo=9.
